onchip_mem_arbiter: RTL
=======================

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width; byteenable width SHALL be DATA_W/8.
REQ-003 The block SHALL have parameter WEIGHT0, default 2, consecutive contended grants allowed to master 0 per turn (legal range 1..15).
REQ-004 The block SHALL have parameter WEIGHT1, default 1, the same for master 1 (legal range 1..15).
REQ-005 The block SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 The block SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 For N in {0,1}, the block SHALL have port mN_address  in  ADDR_W  requester word address.
REQ-008 For N in {0,1}, the block SHALL have port mN_byteenable  in  DATA_W/8  requester write byte lanes.
REQ-009 For N in {0,1}, the block SHALL have ports mN_read and mN_write  in  1 each  requester read and write strobes.
REQ-010 For N in {0,1}, the block SHALL have port mN_writedata  in  DATA_W  requester write data.
REQ-011 For N in {0,1}, the block SHALL have port mN_waitrequest  out  1  request not accepted this cycle.
REQ-012 For N in {0,1}, the block SHALL have ports mN_readdata  out  DATA_W and mN_readdatavalid  out  1  read response.
REQ-013 The block SHALL have ports mem_address  out  ADDR_W, mem_byteenable  out  DATA_W/8 and mem_writedata  out  DATA_W  to the single-port RAM.
REQ-014 The block SHALL have ports mem_chipselect  out  1, mem_write  out  1 and mem_clken  out  1  RAM controls.
REQ-015 The block SHALL have port mem_readdata  in  DATA_W  RAM data, valid one cycle after the address is registered.

Function
REQ-016 Request from master N SHALL be reqN = mN_read | mN_write; a grant SHALL accept the request in the same cycle.
REQ-017 mN_waitrequest SHALL equal ~gntN combinationally, and SHALL be 1 while reset_n is low.
REQ-018 At most one master SHALL be granted per cycle; a lone requester SHALL always be granted.
REQ-019 State SHALL be ptr (priority owner, 1 bit) and cnt (4 bits); on contention (req0 & req1) the ptr master SHALL be granted, cnt incremented, and when cnt reaches WEIGHT[ptr] ptr SHALL toggle and cnt clear.
REQ-020 ptr and cnt SHALL change only on contended cycles.
REQ-021 The mem_* address, byteenable and writedata outputs SHALL mux the granted master's signals; mem_chipselect SHALL be gnt0|gnt1; mem_write SHALL be chipselect & granted mN_write.
REQ-022 mem_clken SHALL be 1 when reset_n is high and 0 when reset_n is low.
REQ-023 mN_read & mN_write asserted together SHALL be treated as a write, with no read response.
REQ-024 On a granted read, the block SHALL register rv_q = 1 and owner_q = N; next cycle mN_readdatavalid SHALL be rv_q & (owner_q == N); read latency is exactly 1 cycle.
REQ-025 mN_readdata SHALL be driven from mem_readdata unconditionally; it is qualified only by readdatavalid.
REQ-026 Back-to-back reads, including alternating masters, SHALL sustain one grant per cycle with no bubbles.

Reset
REQ-027 Asserting reset_n low SHALL immediately clear ptr to 0, cnt to 0, rv_q to 0 and owner_q to 0.
REQ-028 A read granted in the cycle before reset asserts SHALL produce no readdatavalid.
REQ-029 The first grant after reset release SHALL be in the first cycle with reset_n high and a request present.

Verification
REQ-030 Reset scenario: reset_n low with both masters requesting -> both waitrequest=1, chipselect=0, both readdatavalid=0.
REQ-031 Write/read scenario: m0 writes 0xDEADBEEF, be=0xF, to address 0x005, then reads 0x005 -> mem_write=1 on the write cycle; on the read, m0_readdatavalid=1 one cycle after the grant with m0_readdata=0xDEADBEEF.
REQ-032 Contention scenario: both masters issue continuous reads with WEIGHT0=2, WEIGHT1=1 -> grant sequence m0,m0,m1,m0,m0,m1 and each readdatavalid reaches only its owner.
REQ-033 Lone-requester scenario: m1 requests alone for 3 cycles, then both contend -> m1 is granted 3 times, then m0 wins the first contended cycle (ptr unchanged).
REQ-034 Read+write scenario: m1 asserts read and write together at 0x010 -> mem_write=1 and m1_readdatavalid stays 0.
REQ-035 Mid-operation reset scenario: reset_n is pulsed low the cycle after an m0 read grant -> m0_readdatavalid=0, and after release m0 wins the first contended cycle.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-master weighted round-robin arbiter in front of a single-port on-chip RAM.
// Grants are combinational. Read responses return exactly one cycle after the grant.
module onchip_mem_arbiter #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WEIGHT0 = 2,
  parameter int unsigned WEIGHT1 = 1
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] W0 = CNT_W'(WEIGHT0);
  localparam logic [CNT_W-1:0] W1 = CNT_W'(WEIGHT1);

  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rv_q, rv_d;
  logic             owner_q, owner_d;

  logic             req0, req1, contend;
  logic             gnt0, gnt1, rd_gnt;
  logic [CNT_W-1:0] cnt_inc;

  // Grant decision: a lone requester always wins, contention goes to ptr owner.
  always_comb begin
    req0    = m0_read | m0_write;
    req1    = m1_read | m1_write;
    contend = req0 & req1;
    gnt0    = reset_n & req0 & (~req1 | ~ptr_q);
    gnt1    = reset_n & req1 & (~req0 |  ptr_q);
    // A combined read+write is a write and produces no read response.
    rd_gnt  = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
  end

  // Memory-side mux and requester handshakes.
  always_comb begin
    m0_waitrequest   = ~gnt0;
    m1_waitrequest   = ~gnt1;
    mem_chipselect   = gnt0 | gnt1;
    mem_address      = gnt1 ? m1_address    : m0_address;
    mem_byteenable   = gnt1 ? m1_byteenable : m0_byteenable;
    mem_writedata    = gnt1 ? m1_writedata  : m0_writedata;
    mem_write        = mem_chipselect & (gnt1 ? m1_write : m0_write);
    mem_clken        = reset_n;
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    m0_readdatavalid = rv_q & ~owner_q;
    m1_readdatavalid = rv_q &  owner_q;
  end

  // Weighted turn tracking: only contended cycles advance ptr/cnt.
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rv_d    = rd_gnt;
    owner_d = owner_q;
    cnt_inc = cnt_q + CNT_W'(1);
    if (contend) begin
      if (cnt_inc == (ptr_q ? W1 : W0)) begin
        ptr_d = ~ptr_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    if (rd_gnt) begin
      owner_d = gnt1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      owner_q <= owner_d;
    end
  end

endmodule
